// File: rtl/avalon_multiport_controller.sv
// Avalon-MM master arbitrating NUM_PORTS request/done ports onto one bus.
// Fixed-priority or round-robin grant, optional waitrequest timeout abort.
module avalon_multiport_controller #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int MAX_WAIT   = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              port_read,
  input  logic [NUM_PORTS-1:0]              port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_writedata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_byteenable,
  output logic [DATA_WIDTH-1:0]             port_readdata,
  output logic [NUM_PORTS-1:0]              port_done,
  output logic [NUM_PORTS-1:0]              port_stall,
  output logic [ADDR_WIDTH-1:0]             av_address,
  output logic                              av_read,
  output logic                              av_write,
  output logic [DATA_WIDTH-1:0]             av_writedata,
  output logic [DATA_WIDTH/8-1:0]           av_byteenable,
  input  logic                              av_waitrequest,
  input  logic [DATA_WIDTH-1:0]             av_readdata,
  output logic                              busy,
  output logic                              timeout_error
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [BW-1:0]          be_q, be_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   done_q, done_d;
  logic                   terr_q, terr_d;

  logic [NUM_PORTS-1:0]   req;
  logic [PW-1:0]          win;
  logic                   found;

  assign req = port_read | port_write;

  // Round robin: first pass above the pointer, second pass wraps from 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i] &&
          (ARB_MODE == 0 || i > int'(rr_ptr_q))) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    done_d     = '0;
    terr_d     = terr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ACCESS;
          grant_d    = win;
          wait_cnt_d = '0;
          if (ARB_MODE == 1) rr_ptr_d = win;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (PW'(i) == win) begin
              addr_d  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = port_writedata[i*DATA_WIDTH +: DATA_WIDTH];
              be_d    = port_byteenable[i*BW +: BW];
              wr_d    = port_write[i];
              rd_d    = ~port_write[i];
            end
          end
        end
      end
      ACCESS: begin
        if (!av_waitrequest) begin
          if (rd_q) rdata_d = av_readdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          for (int i = 0; i < NUM_PORTS; i++)
            done_d[i] = (PW'(i) == grant_q);
        end else if (MAX_WAIT > 0 && wait_cnt_q == CNT_LAST) begin
          rdata_d = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          terr_d  = 1'b1;
          state_d = DONE;
          for (int i = 0; i < NUM_PORTS; i++)
            done_d[i] = (PW'(i) == grant_q);
        end else if (MAX_WAIT > 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= PW'(NUM_PORTS - 1);
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      done_q     <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
    end
  end

  assign av_address    = addr_q;
  assign av_writedata  = wdata_q;
  assign av_byteenable = be_q;
  assign av_read       = rd_q;
  assign av_write      = wr_q;
  assign port_readdata = rdata_q;
  assign port_done     = done_q;
  assign port_stall    = req & ~done_q;
  assign busy          = (state_q != IDLE);
  assign timeout_error = terr_q;

endmodule

// File: tb/tb_avalon_multiport_controller.sv
// Randomized bench: two controllers (fixed priority / round robin with
// timeout) driven by random requesters, checked by a queue scoreboard.
module tb_avalon_multiport_controller;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CYCLES = 3000;

  typedef struct packed {
    logic          rd;
    logic          to;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5A5A_0F0F;
  endfunction

  // Slave inserts as many wait states as the low three address bits.
  function automatic int waits_of(input logic [AW-1:0] a);
    return int'(a[2:0]);
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int ptr,
                              input int mode);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (mode == 0) ? k - 1 : (ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h",
               name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int MW = 4 * g;

    logic          rst;
    logic [N-1:0]  prd, pwr, pdone, pstall;
    logic [N*AW-1:0] paddr;
    logic [N*DW-1:0] pwd;
    logic [N*BW-1:0] pbe;
    logic [DW-1:0] prdata, av_wd, av_rdata;
    logic [AW-1:0] av_addr;
    logic [BW-1:0] av_be;
    logic          av_rd, av_wr, av_wait, busy, terr;
    logic [2:0]    scnt;
    logic          rst_edge = 1'b1;
    logic          fin_g = 1'b0;
    exp_t          exp_q[N][$];

    avalon_multiport_controller #(
      .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .ARB_MODE(g), .MAX_WAIT(MW)
    ) dut (
      .clk(clk), .reset(rst),
      .port_read(prd), .port_write(pwr),
      .port_address(paddr), .port_writedata(pwd),
      .port_byteenable(pbe), .port_readdata(prdata),
      .port_done(pdone), .port_stall(pstall),
      .av_address(av_addr), .av_read(av_rd), .av_write(av_wr),
      .av_writedata(av_wd), .av_byteenable(av_be),
      .av_waitrequest(av_wait), .av_readdata(av_rdata),
      .busy(busy), .timeout_error(terr)
    );

    always @(posedge clk) begin
      rst_edge <= rst;
      if (rst || !(av_rd | av_wr) || !av_wait) scnt <= '0;
      else scnt <= scnt + 3'd1;
    end

    assign av_wait  = (av_rd | av_wr) && (int'(scnt) < waits_of(av_addr));
    assign av_rdata = av_wait ? 32'hBAD0_BAD0 : slave_data(av_addr);

    logic [AW-1:0] a;
    logic          wr;
    int            guard;

    initial begin : drv
      rst = 1'b1; prd = '0; pwr = '0;
      paddr = '0; pwd = '0; pbe = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int cyc = 0; cyc < CYCLES + 300; cyc++) begin
        @(posedge clk);
        #1 rst = 1'b0;
        for (int p = 0; p < N; p++) begin
          if ((prd[p] | pwr[p]) && pdone[p]) begin
            prd[p] = 1'b0;
            pwr[p] = 1'b0;
          end
          if (cyc < CYCLES && !(prd[p] | pwr[p]) &&
              $urandom_range(0, 2) == 0) begin
            a = AW'($urandom);
            a[2:0] = ($urandom_range(0, 3) == 0) ?
                     3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            pwr[p] = wr;
            prd[p] = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            paddr[p*AW +: AW] = a;
            pwd[p*DW +: DW]   = $urandom;
            pbe[p*BW +: BW]   = ($urandom_range(0, 7) == 0) ?
                                '0 : BW'($urandom);
            exp_q[p].push_back('{rd: !wr,
                                 to: (MW > 0 && waits_of(a) >= MW),
                                 addr: a});
          end
        end
        if (cyc < CYCLES && (av_rd | av_wr) && $urandom_range(0, 40) == 0)
          rst = 1'b1;
        if (cyc >= CYCLES && !(|(prd | pwr))) break;
      end
      chk("drain_idle", g, |(prd | pwr), 0);
      repeat (3) @(posedge clk);
      for (int p = 0; p < N; p++)
        chk("drain_queue", g, exp_q[p].size(), 0);
      fin_g = 1'b1;
    end

    logic          strobe, in_acc, prev_idle, te_m;
    logic [N-1:0]  snap_req, snap_wr, ed;
    logic [N*AW-1:0] snap_addr;
    logic [N*DW-1:0] snap_wd;
    logic [N*BW-1:0] snap_be;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wd, rd_m, er;
    logic [BW-1:0] lat_be;
    logic          lat_wr;
    int            ptr, cur_w, len, w, xl;
    exp_t          e;

    initial begin : mon
      in_acc = 0; prev_idle = 0; te_m = 0; rd_m = '0;
      ptr = N - 1; cur_w = 0; len = 0;
      snap_req = '0; snap_wr = '0;
      snap_addr = '0; snap_wd = '0; snap_be = '0;
      forever begin
        @(negedge clk);
        strobe = av_rd | av_wr;
        for (int p = 0; p < N; p++)
          chk("stall", g, pstall[p], (prd[p] | pwr[p]) & ~pdone[p]);
        if (rst_edge) begin
          chk("rst_strobe", g, strobe, 0);
          chk("rst_done", g, pdone, 0);
          chk("rst_busy", g, busy, 0);
          chk("rst_terr", g, terr, 0);
          chk("rst_rdata", g, prdata, 0);
          chk("rst_addr", g, av_addr, 0);
          chk("rst_wdata", g, av_wd, 0);
          chk("rst_be", g, av_be, 0);
          ptr = N - 1; te_m = 0; rd_m = '0; in_acc = 0;
        end else begin
          chk("grant_time", g, strobe && !in_acc,
              prev_idle && (snap_req != '0));
          if (strobe && !in_acc) begin
            w = pick(snap_req, ptr, g);
            chk("grant_valid", g, w >= 0, 1);
            if (w >= 0) begin
              if (g == 1) ptr = w;
              cur_w = w;
              chk("av_addr", g, av_addr, snap_addr[w*AW +: AW]);
              chk("av_write", g, av_wr, snap_wr[w]);
              chk("av_read", g, av_rd, !snap_wr[w]);
              chk("av_wdata", g, av_wd, snap_wd[w*DW +: DW]);
              chk("av_be", g, av_be, snap_be[w*BW +: BW]);
            end
            lat_addr = av_addr; lat_wd = av_wd;
            lat_be = av_be; lat_wr = av_wr; len = 0;
          end else if (strobe) begin
            chk("hold_addr", g, av_addr, lat_addr);
            chk("hold_wdata", g, av_wd, lat_wd);
            chk("hold_be", g, av_be, lat_be);
            chk("hold_dir", g, {av_rd, av_wr}, {!lat_wr, lat_wr});
          end
          if (strobe) len++;
          ed = '0;
          if (in_acc && !strobe) begin
            ed[cur_w] = 1'b1;
            xl = (MW > 0 && waits_of(lat_addr) >= MW) ?
                 MW : waits_of(lat_addr) + 1;
            chk("access_len", g, len, xl);
          end
          chk("done", g, pdone, ed);
          for (int p = 0; p < N; p++) begin
            if (pdone[p]) begin
              chk("done_pending", g, exp_q[p].size() > 0, 1);
              if (exp_q[p].size() > 0) begin
                e = exp_q[p].pop_front();
                te_m = te_m | e.to;
                er = e.to ? '0 : (e.rd ? slave_data(e.addr) : rd_m);
                rd_m = er;
              end
            end
          end
          chk("rdata", g, prdata, rd_m);
          chk("timeout_err", g, terr, te_m);
          chk("busy", g, busy, strobe || (|pdone));
          in_acc = strobe;
        end
        prev_idle = !strobe && !(|pdone) && !rst;
        snap_req = prd | pwr; snap_wr = pwr;
        snap_addr = paddr; snap_wd = pwd; snap_be = pbe;
      end
    end
  end

  initial begin
    wait (gen[0].fin_g && gen[1].fin_g);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/avalon_multiport_controller.md
Name: avalon_multiport_controller

Overview:
Parametrised Avalon-MM master controller that arbitrates NUM_PORTS independent requesters onto one Avalon bus. Typical requesters are instruction fetch, data load/store and debug. Each port has a simple request/done handshake and a combinational stall output for freezing its pipeline. Adds round-robin arbitration, per-port byte enables and a wait-state timeout with a sticky error flag.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8); port 0 has highest fixed priority
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8); BE_WIDTH = DATA_WIDTH/8
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
MAX_WAIT, 0, 0 = no timeout; otherwise the abort threshold in consecutive waitrequest cycles

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
port_read  in  NUM_PORTS  per-port read request, held until done
port_write  in  NUM_PORTS  per-port write request, held until done
port_address  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
port_writedata  in  NUM_PORTS*DATA_WIDTH  packed write data
port_byteenable  in  NUM_PORTS*BE_WIDTH  packed byte enables
port_readdata  out  DATA_WIDTH  read data, shared by all ports, valid while port_done[i]=1
port_done  out  NUM_PORTS  one-cycle completion pulse per port
port_stall  out  NUM_PORTS  combinational: port requesting and not done this cycle
av_address  out  ADDR_WIDTH  Avalon address
av_read  out  1  Avalon read strobe
av_write  out  1  Avalon write strobe
av_writedata  out  DATA_WIDTH  Avalon write data
av_byteenable  out  BE_WIDTH  Avalon byte enables
av_waitrequest  in  1  slave stall
av_readdata  in  DATA_WIDTH  Avalon read data, valid on read when waitrequest=0
busy  out  1  high in ACCESS and DONE
timeout_error  out  1  sticky, set on timeout abort

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
- Reset values: all av_* = 0, port_readdata = 0, port_done = 0, busy = 0, timeout_error = 0.
- Reset values (internal): state = IDLE, wait counter = 0, round-robin pointer = NUM_PORTS-1, so port 0 is served first.
- A port requests when port_read[i] | port_write[i]. If both are high, the access is a write and read is ignored.
- IDLE: if any port requests, pick winner g.
  - ARB_MODE 0: lowest requesting index.
  - ARB_MODE 1: first requester searching from pointer+1 with wrap-around; pointer <= g at grant.
  - At the edge, register address, writedata, byteenable and direction from port g. Assert av_read or av_write. Enter ACCESS.
  - If no port requests, stay in IDLE.
- ACCESS: av_* held stable while av_waitrequest=1. On a cycle with av_waitrequest=0, at the next edge:
  - deassert av_read and av_write;
  - capture av_readdata into port_readdata (reads only; port_readdata unchanged for writes);
  - port_done[g] <= 1; enter DONE.
- DONE: port_done[g] high for exactly this cycle. Requests are not sampled. Next state is IDLE.
  - Requester may drop its request in the DONE cycle or keep it high. A held request starts a new access from IDLE.
- Latency, zero-wait slave: request visible cycle 0; av strobe cycle 1; port_done cycle 2. Maximum throughput is one access per 3 cycles.
- Non-granted ports keep port_stall high and their requests pending. No starvation in ARB_MODE 1.
- byteenable = 0: the access is still issued unchanged.
- Timeout (MAX_WAIT>0): counter increments each ACCESS cycle with waitrequest=1 and clears on entering ACCESS. When it reaches MAX_WAIT, at the next edge:
  - abort: av strobes go to 0, port_readdata <= 0, port_done[g] <= 1, state DONE;
  - timeout_error <= 1, held until reset.
- Request inputs changing during ACCESS: ignored, because the latched copy drives the bus.
- Reset mid-access: next edge returns to IDLE with strobes 0. No done pulse. Pending access is discarded.

Test Plan:
- Zero-wait read, NUM_PORTS=2: port1 read addr 0x100, slave returns 0xDEADBEEF -> av_read high cycle 1, port_done[1] and port_readdata=0xDEADBEEF cycle 2, port_stall[1] high cycles 0-1.
- Write with 3 wait states: port0 write 0x200 data 0x12345678 be 4'b0011 -> av_write, address, data and be held 4 cycles; port_done[0] one cycle after waitrequest falls.
- Fixed priority (ARB_MODE 0): port0 and port1 both request continuously -> only port0 is granted; port_stall[1] stays high.
- Round robin (ARB_MODE 1, NUM_PORTS=3): all three request continuously -> grant order 0,1,2,0,1,2, one done pulse per 3 cycles.
- Timeout (MAX_WAIT=4): waitrequest stuck high -> abort after 4 wait cycles; port_done pulses with readdata 0; timeout_error stays 1 until reset.
- Reset asserted during ACCESS -> strobes 0 next edge, no done pulse; next request is served from IDLE normally.
